// File: rtl/ir_half_writer.sv
// ir_half_writer: stores a 16-bit word into byte-wide memory as two
// consecutive single-byte writes at addr and addr+1. Each byte is held on the
// bus until the memory acknowledges it, so any number of wait states is
// tolerated.
//
// Parameters
//   ADDR_W     memory address width
//   LOW_FIRST  1: data[7:0] at addr, data[15:8] at addr+1
//              0: data[15:8] at addr, data[7:0] at addr+1
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      request, sampled only while ready_o is 1
//   addr_i       base byte address, captured with start_i
//   data_i       word to store, captured with start_i
//   mem_ack_i    memory accepted the current byte this cycle
//   mem_addr_o   byte address presented to memory
//   mem_data_o   byte presented to memory
//   mem_we_o     write strobe, high while a byte is pending
//   ready_o      block can accept start_i this cycle
//   done_o       one-cycle pulse after both bytes are written
module ir_half_writer #(
    parameter int unsigned ADDR_W    = 8,
    parameter bit          LOW_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       data_i,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    output logic              mem_we_o,
    output logic              ready_o,
    output logic              done_o
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0]   mem_data_q, mem_data_d;
    logic                mem_we_q, mem_we_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;

    // Byte selection: the first byte comes straight from the incoming word so
    // it can be on the bus the cycle after start; the second from the capture.
    logic [BYTE_W-1:0]   first_byte_c;
    logic [BYTE_W-1:0]   second_byte_c;

    assign first_byte_c  = LOW_FIRST ? data_i[7:0]  : data_i[15:8];
    assign second_byte_c = LOW_FIRST ? word_q[15:8] : word_q[7:0];

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            word_q     <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            word_q     <= word_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        word_d     = word_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        ready_d    = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    base_d     = addr_i;
                    word_d     = data_i;
                    mem_addr_d = addr_i;
                    mem_data_d = first_byte_c;
                    mem_we_d   = 1'b1;
                    state_d    = ST_FIRST;
                end else begin
                    ready_d    = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_FIRST: begin
                mem_we_d = 1'b1;
                if (mem_ack_i) begin
                    // Address wraps modulo 2^ADDR_W by construction
                    mem_addr_d = base_q + ADDR_W'(1);
                    mem_data_d = second_byte_c;
                    state_d    = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (mem_ack_i) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    mem_we_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_we_o   = mem_we_q;
    assign ready_o    = ready_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_ir_half_writer.sv
// Bench for ir_half_writer: two instances (low-first and high-first) share
// stimulus and are compared every cycle against a queue-of-pending-writes
// model, plus directed scenarios with hand-computed expectations.
module tb_ir_half_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        ack;

    logic [7:0]  a1, a0;
    logic [7:0]  d1, d0;
    logic        we1, we0, rdy1, rdy0, dn1, dn0;

    int checks = 0;
    int errors = 0;
    int acks1  = 0;

    always #5 clk = ~clk;

    ir_half_writer #(.ADDR_W(8), .LOW_FIRST(1'b1)) u_lo (
        .clk_i(clk), .rst_i(rst), .start_i(start), .addr_i(addr), .data_i(data),
        .mem_ack_i(ack), .mem_addr_o(a1), .mem_data_o(d1), .mem_we_o(we1),
        .ready_o(rdy1), .done_o(dn1)
    );

    ir_half_writer #(.ADDR_W(8), .LOW_FIRST(1'b0)) u_hi (
        .clk_i(clk), .rst_i(rst), .start_i(start), .addr_i(addr), .data_i(data),
        .mem_ack_i(ack), .mem_addr_o(a0), .mem_data_o(d0), .mem_we_o(we0),
        .ready_o(rdy0), .done_o(dn0)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a queue of byte writes still owed to memory. Entry is
    // {addr, byte for low-first instance, byte for high-first instance}.
    logic [23:0] pq[$];
    logic [7:0]  m_addr, m_d1, m_d0;
    logic        m_done;
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            pq.delete();
            m_addr = 8'h00; m_d1 = 8'h00; m_d0 = 8'h00; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (pq.size() != 0) begin
                if (ack) begin
                    void'(pq.pop_front());
                    if (pq.size() == 0) m_done = 1'b1;
                end
            end else if (start) begin
                pq.push_back({addr, data[7:0], data[15:8]});
                pq.push_back({addr + 8'd1, data[15:8], data[7:0]});
            end
            if (pq.size() != 0) {m_addr, m_d1, m_d0} = pq[0];
        end
        model_valid = 1'b1;
    end

    // Acknowledged byte writes seen by the low-first instance
    always @(posedge clk) begin
        if (!rst && we1 && ack) acks1++;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_valid) begin
            chk("we_lo",    16'(we1),   16'(pq.size() != 0));
            chk("we_hi",    16'(we0),   16'(pq.size() != 0));
            chk("ready_lo", 16'(rdy1),  16'(pq.size() == 0));
            chk("ready_hi", 16'(rdy0),  16'(pq.size() == 0));
            chk("done_lo",  16'(dn1),   16'(m_done));
            chk("done_hi",  16'(dn0),   16'(m_done));
            chk("addr_lo",  16'(a1),    16'(m_addr));
            chk("addr_hi",  16'(a0),    16'(m_addr));
            chk("data_lo",  16'(d1),    16'(m_d1));
            chk("data_hi",  16'(d0),    16'(m_d0));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus(input string nm, input logic [7:0] ea, input logic [7:0] ed1,
                       input logic [7:0] ed0);
        chk({nm, "_we"},    16'(we1), 16'h1);
        chk({nm, "_addr"},  16'(a1),  16'(ea));
        chk({nm, "_d_lo"},  16'(d1),  16'(ed1));
        chk({nm, "_d_hi"},  16'(d0),  16'(ed0));
        chk({nm, "_done"},  16'(dn1), 16'h0);
    endtask

    int ack_base;

    initial begin
        rst = 1'b1; start = 1'b0; addr = 8'h00; data = 16'h0000; ack = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", 16'(rdy1), 16'h1);
        chk("rst_we",    16'(we1),  16'h0);
        chk("rst_addr",  16'(a1),   16'h00);
        chk("rst_data",  16'(d0),   16'h00);

        // Basic zero-wait transfer
        start = 1'b1; addr = 8'h10; data = 16'hBEEF;
        tick(); start = 1'b0; addr = 8'h99; data = 16'h5555;
        bus("basic_c1", 8'h10, 8'hEF, 8'hBE);
        tick();
        bus("basic_c2", 8'h11, 8'hBE, 8'hEF);
        tick();
        chk("basic_c3_done",  16'(dn1),  16'h1);
        chk("basic_c3_ready", 16'(rdy1), 16'h1);
        chk("basic_c3_we",    16'(we1),  16'h0);
        chk("basic_c3_hold",  16'(a1),   16'h11);
        tick();
        chk("basic_c4_done",  16'(dn1),  16'h0);
        chk("basic_c4_ready", 16'(rdy1), 16'h1);

        // Order swap
        start = 1'b1; addr = 8'h20; data = 16'h1234;
        tick(); start = 1'b0;
        bus("swap_c1", 8'h20, 8'h34, 8'h12);
        tick();
        bus("swap_c2", 8'h21, 8'h12, 8'h34);
        tick();
        chk("swap_done", 16'(dn0), 16'h1);
        tick();

        // Wait states: ack only in cycles 3 and 7, stray starts ignored
        ack_base = acks1;
        start = 1'b1; addr = 8'h40; data = 16'hA55A;
        tick();
        for (int c = 1; c <= 8; c++) begin
            ack   = (c == 3 || c == 7);
            start = (c == 2 || c == 5);
            addr  = 8'hEE; data = 16'h7777;
            if (c <= 3)      bus("wait_first",  8'h40, 8'h5A, 8'hA5);
            else if (c <= 7) bus("wait_second", 8'h41, 8'hA5, 8'h5A);
            else             chk("wait_done_c8", 16'(dn1), 16'h1);
            if (c < 8) tick();
        end
        start = 1'b0; ack = 1'b1;
        chk("wait_ack_count", 16'(acks1 - ack_base), 16'd2);
        tick();

        // Wrap plus back-to-back start in DONE
        start = 1'b1; addr = 8'hFF; data = 16'hCAFE;
        tick();
        bus("wrap_c1", 8'hFF, 8'hFE, 8'hCA);
        start = 1'b1; addr = 8'h77; data = 16'hFFFF;
        tick();
        bus("wrap_c2", 8'h00, 8'hCA, 8'hFE);
        start = 1'b1; addr = 8'h00; data = 16'h0102;
        tick();
        chk("wrap_done",  16'(dn1),  16'h1);
        chk("wrap_ready", 16'(rdy1), 16'h1);
        tick(); start = 1'b0;
        bus("b2b_c1", 8'h00, 8'h02, 8'h01);
        tick();
        bus("b2b_c2", 8'h01, 8'h01, 8'h02);
        tick();
        chk("b2b_done", 16'(dn1), 16'h1);
        tick();

        // Reset in SECOND during a wait state
        start = 1'b1; addr = 8'h50; data = 16'h1111;
        tick(); start = 1'b0;
        tick(); ack = 1'b0;
        bus("rst_mid_second", 8'h51, 8'h11, 8'h11);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rstmid_we",    16'(we1),  16'h0);
        chk("rstmid_addr",  16'(a1),   16'h00);
        chk("rstmid_data",  16'(d1),   16'h00);
        chk("rstmid_ready", 16'(rdy1), 16'h1);
        chk("rstmid_done",  16'(dn1),  16'h0);
        ack = 1'b1; start = 1'b1; addr = 8'h60; data = 16'h7788;
        tick(); start = 1'b0;
        bus("fresh_c1", 8'h60, 8'h88, 8'h77);
        tick();
        bus("fresh_c2", 8'h61, 8'h77, 8'h88);
        tick();
        chk("fresh_done", 16'(dn1), 16'h1);

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) == 0);
            addr  = 8'($urandom);
            data  = 16'($urandom);
            ack   = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; start = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_half_writer.md
# ir_half_writer

Byte-serial word writer: accepts a 16-bit word plus a byte address and stores it into byte-wide memory as two consecutive single-byte writes, low half then high half (or high then low, by parameter). It is the store-side counterpart of the IR's two-step half-word load path, sitting between the datapath's 16-bit registers and the 8-bit memory bus. Each byte write completes on a memory acknowledge, so the block tolerates wait states.

## Interface
- `ADDR_W`, 8: memory address width.
- `LOW_FIRST`, 1: 1 writes `data[7:0]` to `addr` then `data[15:8]` to `addr+1`; 0 writes `data[15:8]` to `addr` then `data[7:0]` to `addr+1`.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `ready` is 1.
- `addr`  in  ADDR_W  base byte address, captured with `start`.
- `data`  in  16  word to store, captured with `start`.
- `mem_ack`  in  1  memory accepted the current byte this cycle.
- `mem_addr`  out  ADDR_W  byte address presented to memory.
- `mem_data`  out  8  byte presented to memory.
- `mem_we`  out  1  write strobe; high while a byte is pending.
- `ready`  out  1  block can accept `start` this cycle.
- `done`  out  1  one-cycle pulse: both bytes written.

## Operation
- States: IDLE, FIRST, SECOND, DONE.
- IDLE: `ready`=1. On `start`=1: capture `addr` into base register, `data` into word register, go to FIRST. `start`=0: stay.
- FIRST: `mem_we`=1, `mem_addr`=base, `mem_data`=first byte per `LOW_FIRST`. Hold all outputs stable until `mem_ack`=1; then go to SECOND.
- SECOND: `mem_we`=1, `mem_addr`=base+1 modulo 2^ADDR_W (all-ones wraps to 0), `mem_data`=other byte. Hold until `mem_ack`=1; then go to DONE.
- DONE: `done`=1, `mem_we`=0, `ready`=1. `start`=1 here captures new operands and goes directly to FIRST (back-to-back); otherwise go to IDLE.
- `start` in FIRST/SECOND: ignored; captured registers do not change. Changes on `addr`/`data` after capture have no effect.
- `mem_ack` outside FIRST/SECOND: ignored.
- `mem_addr`/`mem_data` when `mem_we`=0: hold last driven values (0 after reset).
- Address increment is ADDR_W-bit modular; no carry out, no error.

## Timing
- Reset (synchronous, `rst`=1 at an edge): state IDLE; `mem_we`=0, `done`=0, `ready`=1, `mem_addr`=0, `mem_data`=0, captured registers 0. Reset overrides everything, including mid-transfer: an in-flight write drops `mem_we` the cycle after the reset edge, no `done` is produced, the second byte is never written.
- Zero-wait memory (`mem_ack` tied 1): `start` at edge 0 -> FIRST during cycle 1, SECOND cycle 2, DONE (`done`=1) cycle 3. Minimum 3 cycles per word; back-to-back throughput one word per 3 cycles.
- Each wait cycle (`mem_ack`=0 in FIRST or SECOND) adds exactly one cycle.
- A byte counts as written at the rising edge where `mem_we`=1 and `mem_ack`=1; the next byte's address/data appear the following cycle.
- All outputs registered or decoded from state only; no combinational path from `mem_ack` or `start` to any output.

## Test plan
- Basic, `LOW_FIRST`=1, `mem_ack`=1: start with addr=0x10, data=0xBEEF -> cycle 1 write (0x10, 0xEF), cycle 2 write (0x11, 0xBE), cycle 3 `done`=1, cycle 4 IDLE, `ready`=1.
- Order swap, `LOW_FIRST`=0: addr=0x20, data=0x1234 -> writes (0x20, 0x12) then (0x21, 0x34), `done` after second ack.
- Wait states: addr=0x40, data=0xA55A, `mem_ack` low 2 cycles in FIRST and 3 in SECOND -> outputs stable throughout each wait, `done` on cycle 8, exactly two acknowledged writes.
- Wrap and back-to-back: addr=0xFF, data=0xCAFE with `start` re-asserted in DONE with addr=0x00, data=0x0102 -> writes (0xFF,0xFE),(0x00,0xCA), `done`, then immediately (0x00,0x02),(0x01,0x01), second `done`; `start` pulses during FIRST/SECOND ignored.
- Reset mid-operation: reset asserted in SECOND while `mem_ack`=0 -> next cycle `mem_we`=0, `mem_addr`=0, `mem_data`=0, `ready`=1, no `done`; a fresh start then completes normally.
